// File: rtl/operand_input_fifo.sv
// Operand input FIFO: buffers {clear_mult, A, B} entries between the pin decoder
// and the MAC datapath, with valid/ready on both sides.
module operand_input_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_a_in,
    input  logic [DATA_W-1:0]          data_b_in,
    input  logic                       clear_mult_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [DATA_W-1:0]          data_a_out,
    output logic [DATA_W-1:0]          data_b_out,
    output logic                       clear_mult_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 1 + 2 * DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_LEVEL);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    // ready_out depends on registered state only, so a full FIFO
    // cannot accept in the same cycle it is popped.
    assign ready_out   = (cnt != FULL) && !rst;
    assign valid_out   = (cnt != '0);
    assign push        = valid_in && ready_out;
    assign pop         = valid_out && ready_in;
    assign almost_full = (cnt >= AF);
    assign count       = cnt;

    assign head = valid_out ? mem[rptr] : '0;
    assign {clear_mult_out, data_a_out, data_b_out} = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Flush leaves storage untouched; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wptr] <= {clear_mult_in, data_a_in, data_b_in};
        end
    end

endmodule

// File: tb/tb_operand_input_fifo.sv
// Scoreboard bench for operand_input_fifo: a queue model tracks entries
// and occupancy; directed steps cover fill, wrap, simultaneous ops, flush, reset.
module tb_operand_input_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_a_in;
    logic [DW-1:0] data_b_in;
    logic          clear_mult_in;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] data_a_out;
    logic [DW-1:0] data_b_out;
    logic          clear_mult_out;
    logic          valid_out;
    logic          ready_in;
    logic          flush;
    logic [CW-1:0] count;
    logic          almost_full;

    operand_input_fifo #(
        .DATA_W(DW),
        .DEPTH(DEPTH),
        .AF_LEVEL(AF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_a_in(data_a_in),
        .data_b_in(data_b_in),
        .clear_mult_in(clear_mult_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .data_a_out(data_a_out),
        .data_b_out(data_b_out),
        .clear_mult_out(clear_mult_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .flush(flush),
        .count(count),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    int n;
    logic [2*DW:0] sb [$];
    logic [2*DW:0] exp_head;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: queue size is the expected occupancy; handshakes are
    // decided from the model, not from DUT outputs.
    always @(negedge clk) begin
        if (mon_on) begin
            n = sb.size();
            chk("count", 32'(count), n);
            chk("valid", 32'(valid_out), 32'(n != 0));
            chk("ready", 32'(ready_out), 32'((n != DEPTH) && !rst));
            chk("afull", 32'(almost_full), 32'(n >= AF));
            if (n == 0)
                chk("idle_dat", {clear_mult_out, data_a_out, data_b_out}, 0);
            else
                chk("head", {clear_mult_out, data_a_out, data_b_out},
                    32'(sb[0]));
            if (rst || flush) begin
                sb.delete();
            end else begin
                if (n != 0 && ready_in)
                    exp_head = sb.pop_front();
                if (n != DEPTH && valid_in)
                    sb.push_back({clear_mult_in, data_a_in, data_b_in});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic c);
        bit ok;
        ok = 1'b0;
        valid_in      = 1'b1;
        data_a_in     = a;
        data_b_in     = b;
        clear_mult_in = c;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = ready_out;
            step();
        end
        valid_in      = 1'b0;
        clear_mult_in = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        data_a_in     = '0;
        data_b_in     = '0;
        clear_mult_in = 1'b0;
        valid_in      = 1'b0;
        ready_in      = 1'b0;
        flush         = 1'b0;

        step();
        mon_on = 1'b1;
        chk("rst_ready", 32'(ready_out), 0);
        step();
        chk("rst_cnt", 32'(count), 0);
        chk("rst_valid", 32'(valid_out), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_out), 1);

        // single pass-through
        ready_in = 1'b1;
        push(8'h12, 8'h34, 1'b1);
        chk("pt_valid", 32'(valid_out), 1);
        chk("pt_a", 32'(data_a_out), 32'h12);
        chk("pt_b", 32'(data_b_out), 32'h34);
        chk("pt_clr", 32'(clear_mult_out), 1);
        step();
        chk("pt_gone", 32'(valid_out), 0);
        chk("pt_zero_a", 32'(data_a_out), 0);

        // fill and stall
        ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(DW'(i), DW'(8'hA0 + i), 1'(i));
            chk("fill_cnt", 32'(count), i);
            chk("fill_af", 32'(almost_full), 32'(i >= AF));
        end
        chk("full_ready", 32'(ready_out), 0);
        valid_in  = 1'b1;
        data_a_in = 8'h99;
        repeat (3) step();
        valid_in = 1'b0;
        chk("no_5th", 32'(count), 4);

        // drain in order, then wrap pointers
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_cnt", 32'(count), 3 - i);
        end
        ready_in = 1'b0;
        for (int i = 5; i <= 7; i++)
            push(DW'(i), DW'(8'hB0 + i), 1'b0);
        chk("wrap_cnt", 32'(count), 3);
        chk("wrap_head", 32'(data_a_out), 32'h05);
        ready_in = 1'b1;
        repeat (3) step();
        chk("wrap_empty", 32'(count), 0);
        ready_in = 1'b0;

        // simultaneous push/pop at count 2
        push(8'h21, 8'h01, 1'b0);
        push(8'h22, 8'h02, 1'b1);
        ready_in  = 1'b1;
        valid_in  = 1'b1;
        data_a_in = 8'h23;
        data_b_in = 8'h03;
        step();
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("pp_cnt", 32'(count), 2);
        chk("pp_head", 32'(data_a_out), 32'h22);

        // full with pop: no push that cycle
        push(8'h24, 8'h04, 1'b0);
        push(8'h25, 8'h05, 1'b0);
        chk("full2_cnt", 32'(count), 4);
        ready_in  = 1'b1;
        valid_in  = 1'b1;
        data_a_in = 8'h40;
        step();
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("fullpop_cnt", 32'(count), 3);

        // flush with a concurrent push
        flush     = 1'b1;
        valid_in  = 1'b1;
        data_a_in = 8'h55;
        step();
        flush    = 1'b0;
        valid_in = 1'b0;
        chk("flush_cnt", 32'(count), 0);
        chk("flush_valid", 32'(valid_out), 0);
        ready_in = 1'b1;
        push(8'h66, 8'h06, 1'b1);
        chk("post_flush_a", 32'(data_a_out), 32'h66);
        step();
        chk("post_flush_cnt", 32'(count), 0);

        // reset mid-stream with a push pending
        ready_in = 1'b0;
        push(8'h71, 8'h11, 1'b0);
        push(8'h72, 8'h12, 1'b1);
        rst       = 1'b1;
        valid_in  = 1'b1;
        data_a_in = 8'h73;
        step();
        chk("mid_rst_cnt", 32'(count), 0);
        chk("mid_rst_ready", 32'(ready_out), 0);
        rst      = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("mid_rst_rel", 32'(ready_out), 1);
        step();
        chk("sb_empty", sb.size(), 0);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
